// File: rtl/escrever_rajada.sv
// Purpose : burst pixel writer; unpacks IN_W-bit words into LANES pixels and writes them to consecutive RAM addresses.
// Latency : first RAM write 2 edges after start (if in_valid is already high); LANES+1 cycles per word; done 1 cycle after the last write-enable drop.
// Backpr. : valid/ready on the input side; in_ready is high only in LOAD without abort; the source holds the word until accepted.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   start, abort             begin a burst (sampled in IDLE) / cancel the running burst
//   endereco_base            burst base address (low ADDR_W bits used), latched on start
//   word_count               number of packed words in the burst, latched on start
//   dados_in, in_valid       packed input word and its valid
//   in_ready                 word accepted on this edge when in_valid is also high
//   data, wraddress, wren    registered RAM write port
//   busy, done               not-idle flag, one-cycle completion pulse
module escrever_rajada #(
   parameter int IN_W      = 32,
   parameter int DATA_W    = 8,   // IN_W must be a multiple of DATA_W
   parameter int ADDR_W    = 12,
   parameter int CNT_W     = 13,
   parameter int ADDR_STEP = 1,
   parameter int MSB_FIRST = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [31:0]       endereco_base,
   input  logic [CNT_W-1:0]  word_count,
   input  logic [IN_W-1:0]   dados_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] wraddress,
   output logic              wren,
   output logic              busy,
   output logic              done
);

   localparam int LANES = IN_W / DATA_W;
   localparam int LW    = $clog2(LANES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]    words_rem, words_nxt;
   logic [LW-1:0]       lane_idx, lane_nxt;      // next lane to present; LANES means word exhausted
   logic [IN_W-1:0]     word_reg, word_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic [ADDR_W-1:0]   wraddress_nxt;
   logic                wren_nxt;
   logic                done_nxt;

   // Only the low ADDR_W bits of the base address address the RAM.
   generate
      if (ADDR_W < 32) begin : g_base_hi
         logic unused_base_hi;
         assign unused_base_hi = ^endereco_base[31:ADDR_W];
      end
   endgenerate

   // Pixel k of word w in write order; MSB_FIRST reverses the lane order.
   function automatic logic [DATA_W-1:0] lane_of(input logic [IN_W-1:0] w, input logic [LW-1:0] k);
      int            p;
      logic [IN_W-1:0] sh;
      p  = (MSB_FIRST != 0) ? (LANES - 1 - int'(k)) : int'(k);
      sh = w >> (p * DATA_W);
      return sh[DATA_W-1:0];
   endfunction

   assign in_ready = (state == ST_LOAD) && !abort;
   assign busy     = (state != ST_IDLE);

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      words_nxt     = words_rem;
      lane_nxt      = lane_idx;
      word_nxt      = word_reg;
      data_nxt      = data;
      wraddress_nxt = wraddress;
      wren_nxt      = 1'b0;
      done_nxt      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               ptr_nxt   = endereco_base[ADDR_W-1:0];
               words_nxt = word_count;
               lane_nxt  = '0;
               state_nxt = (word_count == '0) ? ST_DONE : ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (in_valid) begin
               // The capturing edge already writes lane 0.
               word_nxt      = dados_in;
               data_nxt      = lane_of(dados_in, '0);
               wraddress_nxt = ptr;
               wren_nxt      = 1'b1;
               ptr_nxt       = ptr + ADDR_W'(ADDR_STEP);
               lane_nxt      = LW'(1);
               words_nxt     = words_rem - CNT_W'(1);
               state_nxt     = ST_WRITE;
            end
         end

         ST_WRITE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (lane_idx != LW'(LANES)) begin
               data_nxt      = lane_of(word_reg, lane_idx);
               wraddress_nxt = ptr;
               wren_nxt      = 1'b1;
               ptr_nxt       = ptr + ADDR_W'(ADDR_STEP);
               lane_nxt      = lane_idx + LW'(1);
            end else begin
               // Extra edge drops wren; this is the bubble giving LANES+1 cycles per word.
               state_nxt = (words_rem != '0) ? ST_LOAD : ST_DONE;
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
            if (!abort) begin
               done_nxt = 1'b1;
               data_nxt = '0;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         words_rem <= '0;
         lane_idx  <= '0;
         word_reg  <= '0;
         data      <= '0;
         wraddress <= '0;
         wren      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         words_rem <= words_nxt;
         lane_idx  <= lane_nxt;
         word_reg  <= word_nxt;
         data      <= data_nxt;
         wraddress <= wraddress_nxt;
         wren      <= wren_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_escrever_rajada.sv
// Directed bench for escrever_rajada: single word, zero count, stalled multi-word,
// address wrap, MSB-first ordering, abort, start-while-busy and mid-burst reset.
module tb_escrever_rajada;

   logic        clock = 1'b0;
   logic        reset, start, abort, in_valid;
   logic [31:0] endereco_base;
   logic [12:0] word_count;
   logic [31:0] dados_in;

   logic        in_ready, wren, busy, done;
   logic [7:0]  data;
   logic [11:0] wraddress;

   logic        in_ready_m, wren_m, busy_m, done_m;
   logic [7:0]  data_m;
   logic [11:0] wraddress_m;

   int checks = 0;
   int errors = 0;

   logic [19:0] wr_q[$];
   logic [19:0] exp_q[$];
   int          done_cnt = 0;
   int          both_cnt = 0;
   int          load_wr_cnt = 0;

   int          d0, k;
   bit          fin, acc;
   logic [31:0] w3[3];
   logic [7:0]  lane_l[4];
   logic [7:0]  lane_m[4];

   escrever_rajada dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .endereco_base(endereco_base), .word_count(word_count),
      .dados_in(dados_in), .in_valid(in_valid), .in_ready(in_ready),
      .data(data), .wraddress(wraddress), .wren(wren), .busy(busy), .done(done)
   );

   escrever_rajada #(.MSB_FIRST(1)) dut_m (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .endereco_base(endereco_base), .word_count(word_count),
      .dados_in(dados_in), .in_valid(in_valid), .in_ready(in_ready_m),
      .data(data_m), .wraddress(wraddress_m), .wren(wren_m), .busy(busy_m), .done(done_m)
   );

   always #5 clock = ~clock;

   // Write/done monitor, sampled mid-cycle.
   always @(negedge clock) begin
      if (wren) wr_q.push_back({wraddress, data});
      if (done) done_cnt++;
      if (wren && done) both_cnt++;
      if (wren && in_ready) load_wr_cnt++;
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_queue(input string tag);
      chk({tag, "_count"}, wr_q.size(), exp_q.size());
      foreach (exp_q[i])
         chk($sformatf("%s_w%0d", tag, i),
             (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
   endtask

   task automatic go(input logic [31:0] base, input logic [12:0] cnt);
      start         = 1'b1;
      endereco_base = base;
      word_count    = cnt;
      tick;
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      endereco_base = '0; word_count = '0; dados_in = '0;
      repeat (3) tick;

      // Reset state
      chk("rst_wren", wren, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_data", data, 8'h00);
      chk("rst_addr", wraddress, 12'h000);
      chk("rst_m_flags", {in_ready_m, busy_m, done_m, wren_m}, 4'b0000);
      reset = 1'b0;
      tick;

      // Single word, both lane orders
      lane_l = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      lane_m = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      dados_in = 32'hDDCCBBAA; in_valid = 1'b1;
      go(32'h010, 13'd1);
      chk("t2_busy_load", busy, 1'b1);
      chk("t2_ready_load", in_ready, 1'b1);
      chk("t2_wren_load", wren, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk($sformatf("t2_wren%0d", i), wren, 1'b1);
         chk($sformatf("t2_addr%0d", i), wraddress, 12'(32'h010 + i));
         chk($sformatf("t2_data%0d", i), data, lane_l[i]);
         chk($sformatf("t2_msb_data%0d", i), data_m, lane_m[i]);
         chk($sformatf("t2_msb_addr%0d", i), wraddress_m, 12'(32'h010 + i));
         chk($sformatf("t2_ready%0d", i), in_ready, 1'b0);
      end
      tick;
      chk("t2_wren_off", wren, 1'b0);
      chk("t2_done_early", done, 1'b0);
      chk("t2_busy_pre", busy, 1'b1);
      chk("t2_data_hold", data, 8'hDD);
      chk("t2_addr_hold", wraddress, 12'h013);
      tick;
      chk("t2_done", done, 1'b1);
      chk("t2_busy_done", busy, 1'b0);
      chk("t2_data_clr", data, 8'h00);
      chk("t2_wren_done", wren, 1'b0);
      in_valid = 1'b0;
      tick;
      chk("t2_done_off", done, 1'b0);

      // Zero-length burst
      wr_q.delete();
      go(32'h020, 13'd0);
      chk("t5_busy", busy, 1'b1);
      chk("t5_done_early", done, 1'b0);
      tick;
      chk("t5_done", done, 1'b1);
      chk("t5_busy_after", busy, 1'b0);
      tick;
      chk("t5_done_off", done, 1'b0);
      chk("t5_no_writes", wr_q.size(), 0);

      // Three words with random in_valid stalls
      w3[0] = 32'h03020100; w3[1] = 32'h07060504; w3[2] = 32'h0B0A0908;
      wr_q.delete(); d0 = done_cnt; load_wr_cnt = 0;
      dados_in = w3[0]; in_valid = 1'b0;
      go(32'h100, 13'd3);
      k = 0; fin = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
         in_valid = ($urandom_range(0, 1) == 1);
         dados_in = (k < 3) ? w3[k] : 32'h0;
         acc      = in_ready && in_valid;
         tick;
         if (acc) k++;
         if (done) fin = 1'b1;
      end
      in_valid = 1'b0;
      chk("t3_done_seen", fin, 1'b1);
      tick; tick;
      chk("t3_done_cnt", done_cnt - d0, 1);
      chk("t3_words", k, 3);
      chk("t3_load_writes", load_wr_cnt, 0);
      exp_q.delete();
      for (int i = 0; i < 12; i++) exp_q.push_back({12'(32'h100 + i), 8'(i)});
      cmp_queue("t3");

      // Address wrap
      wr_q.delete();
      dados_in = 32'h44332211; in_valid = 1'b1;
      go(32'hFFE, 13'd1);
      repeat (7) tick;
      in_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back({12'hFFE, 8'h11});
      exp_q.push_back({12'hFFF, 8'h22});
      exp_q.push_back({12'h000, 8'h33});
      exp_q.push_back({12'h001, 8'h44});
      cmp_queue("t4");

      // Abort during the second lane
      wr_q.delete(); d0 = done_cnt;
      dados_in = 32'hA4A3A2A1; in_valid = 1'b1;
      go(32'h200, 13'd2);
      tick;
      chk("t6_lane0", {wren, wraddress, data}, {1'b1, 12'h200, 8'hA1});
      tick;
      chk("t6_lane1", {wren, wraddress, data}, {1'b1, 12'h201, 8'hA2});
      abort = 1'b1;
      tick;
      chk("t6_abort_wren", wren, 1'b0);
      chk("t6_abort_busy", busy, 1'b0);
      chk("t6_abort_done", done, 1'b0);
      abort = 1'b0;
      repeat (4) tick;
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_writes", wr_q.size(), 2);
      chk("t6_idle", busy, 1'b0);

      // Abort while in LOAD beats a valid word
      dados_in = 32'h00000055; in_valid = 1'b1;
      go(32'h210, 13'd1);
      abort = 1'b1;
      #1;
      chk("t6_load_ready", in_ready, 1'b0);
      tick;
      chk("t6_load_wren", wren, 1'b0);
      chk("t6_load_busy", busy, 1'b0);
      abort = 1'b0; in_valid = 1'b0;
      tick;
      chk("t6_load_nowrite", wren, 1'b0);
      chk("t6_load_writes", wr_q.size(), 2);

      // Start pulsed while busy is ignored
      wr_q.delete(); d0 = done_cnt;
      dados_in = 32'h0D0C0B0A; in_valid = 1'b1;
      go(32'h300, 13'd1);
      tick;
      start = 1'b1; endereco_base = 32'h0; word_count = 13'd5;
      tick;
      start = 1'b0;
      repeat (6) tick;
      in_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back({12'(32'h300 + i), 8'(32'h0A + i)});
      cmp_queue("t6_ovl");
      chk("t6_ovl_done", done_cnt - d0, 1);
      chk("t6_ovl_idle", busy, 1'b0);

      // Reset mid-burst
      dados_in = 32'h99887766; in_valid = 1'b1;
      go(32'h400, 13'd2);
      tick; tick;
      chk("t1_mid_wren", wren, 1'b1);
      reset = 1'b1;
      tick;
      chk("t1_wren", wren, 1'b0);
      chk("t1_busy", busy, 1'b0);
      chk("t1_done", done, 1'b0);
      chk("t1_in_ready", in_ready, 1'b0);
      tick;
      chk("t1_data", data, 8'h00);
      chk("t1_addr", wraddress, 12'h000);
      reset = 1'b0; in_valid = 1'b0;
      tick;
      chk("t1_after_busy", busy, 1'b0);
      chk("t1_after_wren", wren, 1'b0);

      chk("never_wren_and_done", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
